// File: rtl/bit_stream_tx_if.sv
// Word handshake and serial output bundle for bit_stream_tx.
// master drives words in and watches the line; slave is the transmitter.
interface bit_stream_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             din_valid;
    logic [WIDTH-1:0] din_data;
    logic             din_ready;
    logic             dout;
    logic             dout_valid;
    logic             last;
    logic             busy;

    modport master (
        output din_valid,
        output din_data,
        input  din_ready,
        input  dout,
        input  dout_valid,
        input  last,
        input  busy
    );

    modport slave (
        input  din_valid,
        input  din_data,
        output din_ready,
        output dout,
        output dout_valid,
        output last,
        output busy
    );
endinterface

// File: rtl/bit_stream_tx.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word, shifts it out
// MSB first one bit per clock, then idles GAP cycles before the next word.
module bit_stream_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic            clk,
    input  logic            rst,
    bit_stream_tx_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CW-1:0]    bit_cnt, bit_cnt_next;
    logic [GW-1:0]    gap_cnt, gap_cnt_next;
    logic             dout_q, dout_next;
    logic             dout_valid_q, dout_valid_next;
    logic             last_q, last_next;
    logic             busy_q, busy_next;

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        gap_cnt_next = gap_cnt;
        case (state)
            S_IDLE: begin
                if (bus.din_valid) begin
                    shreg_next   = bus.din_data;
                    bit_cnt_next = '0;
                    state_next   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_next   = {shreg[WIDTH-2:0], 1'b0};
                bit_cnt_next = bit_cnt + 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = (GAP > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                gap_cnt_next = gap_cnt + 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Outputs are registered: decode them from the upcoming state so
        // they line up with the shift register contents of the next cycle.
        dout_valid_next = (state_next == S_SHIFT);
        dout_next       = dout_valid_next & shreg_next[WIDTH-1];
        last_next       = dout_valid_next && (bit_cnt_next == BIT_LAST);
        busy_next       = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_next;
            shreg        <= shreg_next;
            bit_cnt      <= bit_cnt_next;
            gap_cnt      <= gap_cnt_next;
            dout_q       <= dout_next;
            dout_valid_q <= dout_valid_next;
            last_q       <= last_next;
            busy_q       <= busy_next;
        end
    end

    assign bus.din_ready  = (state == S_IDLE);
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.last       = last_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_bit_stream_tx.sv
// Directed bench for bit_stream_tx: GAP=2 instance with a three-ones detector
// on its line, plus a GAP=0 instance for back-to-back timing.
module tb_bit_stream_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bit_stream_tx_if #(.WIDTH(8)) bus  ();
    bit_stream_tx_if #(.WIDTH(8)) bus0 ();

    bit_stream_tx #(.WIDTH(8), .GAP(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
    bit_stream_tx #(.WIDTH(8), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // Mealy "three consecutive 1s" detector fed by the serial line.
    logic [1:0] ones;
    logic       det_rst;
    logic       det_out;
    assign det_rst = ~rst;
    always_ff @(posedge clk or posedge det_rst) begin
        if (det_rst)       ones <= '0;
        else if (bus.dout) ones <= (ones == 2'd2) ? 2'd2 : ones + 2'd1;
        else               ones <= '0;
    end
    assign det_out = bus.dout && (ones == 2'd2);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // det_idx: bit index where the detector must fire, 99 = never, -1 = unchecked
    task automatic send_word(input logic [7:0] w, input int det_idx, input bit disturb);
        logic [7:0] exp_w;
        exp_w = w;
        bus.din_data  = w;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        check("ready_fall", bus.din_ready, 0);
        check("busy_rise", bus.busy, 1);
        for (int i = 0; i < 8; i++) begin
            check("dout", bus.dout, exp_w[7-i]);
            check("dout_valid", bus.dout_valid, 1);
            check("last", bus.last, (i == 7));
            check("shift_ready", bus.din_ready, 0);
            if (det_idx >= 0) check("det", det_out, (i == det_idx));
            if (disturb) begin
                bus.din_data  = bus.din_data ^ 8'h5A;
                bus.din_valid = (i == 3);
            end
            step();
        end
        bus.din_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check("gap_valid", bus.dout_valid, 0);
            check("gap_dout", bus.dout, 0);
            check("gap_last", bus.last, 0);
            check("gap_busy", bus.busy, 1);
            check("gap_ready", bus.din_ready, 0);
            if (det_idx >= 0) check("gap_det", det_out, 0);
            step();
        end
        check("idle_ready", bus.din_ready, 1);
        check("idle_busy", bus.busy, 0);
        check("idle_valid", bus.dout_valid, 0);
        step();
        check("stay_idle_busy", bus.busy, 0);
        check("stay_idle_ready", bus.din_ready, 1);
    endtask

    initial begin
        bus.din_valid  = 1'b0;
        bus.din_data   = '0;
        bus0.din_valid = 1'b0;
        bus0.din_data  = '0;

        // Reset values
        step();
        step();
        check("rst_valid", bus.dout_valid, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b1;
        check("rel_ready", bus.din_ready, 1);
        check("rel_busy", bus.busy, 0);
        check("rel_dout", bus.dout, 0);
        check("rel_valid", bus.dout_valid, 0);
        check("rel_last", bus.last, 0);
        step();

        // Single word, MSB ordering, gap and idle timing
        send_word(8'hB4, 99, 1'b0);

        // Closed loop: detector fires only on bit 5 (third transmitted 1)
        send_word(8'hE0, 2, 1'b0);

        // din_data / din_valid disturbed during SHIFT
        send_word(8'h81, 99, 1'b1);

        // Reset mid-word during the 4th bit of 8'hAA
        bus.din_data  = 8'hAA;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        step();
        step();
        step();
        check("mid_bit4", bus.dout, 0);
        check("mid_valid_pre", bus.dout_valid, 1);
        rst = 1'b0;
        #1;
        check("mid_valid_async", bus.dout_valid, 0);
        check("mid_busy_async", bus.busy, 0);
        check("mid_dout_async", bus.dout, 0);
        check("mid_last_async", bus.last, 0);
        step();
        rst = 1'b1;
        check("mid_rel_ready", bus.din_ready, 1);
        step();
        check("mid_rel_valid", bus.dout_valid, 0);
        send_word(8'h0F, -1, 1'b0);

        // Back-to-back with GAP=0: second MSB 9 cycles after the first
        bus0.din_data  = 8'hFF;
        bus0.din_valid = 1'b1;
        step();
        bus0.din_data = 8'h00;
        for (int c = 0; c < 17; c++) begin
            check("b2b_valid", bus0.dout_valid, (c != 8));
            check("b2b_dout", bus0.dout, (c < 8));
            check("b2b_busy", bus0.busy, (c != 8));
            check("b2b_last", bus0.last, (c == 7 || c == 16));
            if (c == 9) bus0.din_valid = 1'b0;
            step();
        end
        check("b2b_end_valid", bus0.dout_valid, 0);
        check("b2b_end_busy", bus0.busy, 0);
        check("b2b_end_ready", bus0.din_ready, 1);
        step();
        check("b2b_stay_busy", bus0.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
